// File: rtl/cp0_pc_ctrl.sv
// CP0 exception/PC-source controller for the unpipelined MIPS core.
// Holds EPC, Cause and Status and selects the next fetch source each cycle.
module cp0_pc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_fetch_pc,
  input  logic        i_branch_taken,
  input  logic        i_exc_req,
  input  logic [4:0]  i_exc_code,
  input  logic [5:0]  i_irq,
  input  logic        i_eret,
  input  logic        i_mtc0_we,
  input  logic [4:0]  i_mtc0_addr,
  input  logic [31:0] i_mtc0_data,
  output logic [1:0]  o_pcsrc,
  output logic [31:0] o_epc,
  output logic [31:0] o_error_handler,
  output logic [31:0] o_status,
  output logic [31:0] o_cause,
  output logic        o_redirect
);

  typedef enum logic [2:0] {
    EV_SEQ,
    EV_BRANCH,
    EV_ERET,
    EV_IRQ,
    EV_EXC
  } event_t;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  logic [31:0] r_epc;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc_code;
  logic        r_irq_pend;
  logic        r_redirect;

  event_t      w_event;
  logic [1:0]  w_pcsrc;
  logic [31:0] w_epc_n;
  logic [7:0]  w_im_n;
  logic        w_exl_n;
  logic        w_ie_n;
  logic [4:0]  w_exc_code_n;
  logic        w_irq_pend_n;
  logic        w_unused;

  // Fixed priority: exception, interrupt, ERET (only inside a handler), branch.
  always_comb begin
    w_event = EV_SEQ;
    if (!i_rst) begin
      if (i_exc_req)                 w_event = EV_EXC;
      else if (r_irq_pend && !r_exl) w_event = EV_IRQ;
      else if (i_eret && r_exl)      w_event = EV_ERET;
      else if (i_branch_taken)       w_event = EV_BRANCH;
    end
    case (w_event)
      EV_EXC, EV_IRQ: w_pcsrc = 2'b11;
      EV_ERET:        w_pcsrc = 2'b10;
      EV_BRANCH:      w_pcsrc = 2'b01;
      default:        w_pcsrc = 2'b00;
    endcase
  end

  // MTC0 applies first; the event then overrides only the fields it owns.
  always_comb begin
    w_epc_n      = r_epc;
    w_im_n       = r_im;
    w_exl_n      = r_exl;
    w_ie_n       = r_ie;
    w_exc_code_n = r_exc_code;
    w_irq_pend_n = (|(i_irq & r_im)) & r_ie & ~r_exl;
    if (i_mtc0_we && i_mtc0_addr == CP0_STATUS) begin
      w_im_n  = i_mtc0_data[15:8];
      w_exl_n = i_mtc0_data[1];
      w_ie_n  = i_mtc0_data[0];
    end
    if (i_mtc0_we && i_mtc0_addr == CP0_EPC) begin
      w_epc_n = i_mtc0_data;
    end
    case (w_event)
      EV_EXC: begin
        if (!r_exl) w_epc_n = i_fetch_pc;
        w_exl_n      = 1'b1;
        w_exc_code_n = i_exc_code;
      end
      EV_IRQ: begin
        w_epc_n      = i_fetch_pc;
        w_exl_n      = 1'b1;
        w_exc_code_n = 5'd0;
      end
      EV_ERET: w_exl_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_epc      <= 32'd0;
      r_im       <= 8'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_ip       <= 6'd0;
      r_exc_code <= 5'd0;
      r_irq_pend <= 1'b0;
      r_redirect <= 1'b0;
    end else begin
      r_epc      <= w_epc_n;
      r_im       <= w_im_n;
      r_exl      <= w_exl_n;
      r_ie       <= w_ie_n;
      r_ip       <= i_irq;
      r_exc_code <= w_exc_code_n;
      r_irq_pend <= w_irq_pend_n;
      r_redirect <= w_pcsrc[1];
    end
  end

  assign w_unused        = &{1'b0, i_mtc0_data[31:16], i_mtc0_data[7:2]};
  assign o_pcsrc         = w_pcsrc;
  assign o_epc           = r_epc;
  assign o_error_handler = HANDLER_ADDR;
  assign o_status        = {16'd0, r_im, 6'd0, r_exl, r_ie};
  assign o_cause         = {16'd0, r_ip, 3'd0, r_exc_code, 2'd0};
  assign o_redirect      = r_redirect;

endmodule
